db_tc_sched: RTL
================

Name: db_tc_sched

Overview:
- Deblocking tc-parameter scheduler.
- Shares one combinational tc lookup table between two requesters: the vertical-edge filter engine (req0) and the horizontal-edge filter engine (req1).
- Per edge: round-robin arbitration, computes the averaged QP, drives the shared LUT, returns tc on a single tagged response channel with valid/ready backpressure.

Parameters:
- QP_MAX, 51, upper clip applied to the averaged/offset QP index before LUT (LUT adds +2 for intra, so max index 53).

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- req0_valid_i  input  1  edge request from vertical filter
- req0_ready_o  output  1  request accepted this cycle
- req0_qp_p_i  input  6  QP of P side
- req0_qp_q_i  input  6  QP of Q side
- req0_bs_i  input  2  boundary strength 0..2
- req1_valid_i, req1_ready_o, req1_qp_p_i, req1_qp_q_i, req1_bs_i: same as req0, horizontal filter
- rsp_valid_o  output  1  tc result valid
- rsp_ready_i  input  1  consumer accepts result
- rsp_id_o  output  1  0 = req0, 1 = req1
- rsp_tc_o  output  5  tc value
- lut_qp_o  output  6  QP index to shared tc LUT
- lut_type_o  output  1  mb type to LUT: `INTRA when bs==2, else `INTER
- lut_tc_i  input  5  tc from LUT (combinational)
- busy_o  output  1  high when state != IDLE

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, rr_ptr=0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_tc_o=0, busy_o=0.
  - lut_qp_o=0, lut_type_o=`INTER.
  - Captured registers cleared.
  - Reset mid-operation discards the in-flight edge; requesters keep valid asserted and are re-arbitrated.
- FSM states: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - readyN_o is combinational: high only for the granted requester, only in IDLE.
  - Grant rule: if both valid, grant req[rr_ptr]; else grant the single valid one.
  - On grant, capture:
    - id
    - bs
    - qp_avg = (qp_p + qp_q + 1) >> 1, computed in 7 bits, then clipped to QP_MAX
  - Then go to CALC. No valid: stay in IDLE, both ready low.
- CALC:
  - lut_qp_o = captured qp index; lut_type_o from captured bs.
  - Register tc = (bs==0) ? 0 : lut_tc_i into rsp_tc_o; load rsp_id_o; set rsp_valid_o=1.
  - Go to RESP.
- RESP:
  - Hold rsp_valid_o, rsp_id_o and rsp_tc_o stable while rsp_ready_i=0. No new grant.
  - On rsp_valid_o && rsp_ready_i: rsp_valid_o=0 next cycle, rr_ptr = ~served id, go to IDLE.
- lut_qp_o and lut_type_o hold their last value outside CALC.
- Latency: request handshake in cycle N -> rsp_valid_o high from cycle N+2.
- Throughput: 1 edge per 3 cycles with no backpressure.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1...
- Requests arriving during CALC/RESP wait; ready stays low, no loss.
- bs==3 is treated as bs==2.

Optional Feature:
- Macro: DB_TC_OFFSET_EN.
- Defined:
  - Adds input tc_offset_div2_i (4-bit signed, -6..6, slice-level, sampled at grant).
  - QP index = clip3(0, QP_MAX, qp_avg + 2*tc_offset_div2_i), computed signed in 8 bits.
- Undefined:
  - Port absent; index = min(qp_avg, QP_MAX).

Test Plan:
- req0: qp_p=30, qp_q=33, bs=1, rsp_ready=1 -> lut_qp_o=32, lut_type_o=`INTER; rsp_valid at N+2, rsp_id=0, rsp_tc=3.
- req1: qp_p=36, qp_q=36, bs=2 -> lut_type_o=`INTRA, rsp_id=1, rsp_tc=5. Same with bs=0 -> rsp_tc=0.
- Clipping: req0 qp_p=60, qp_q=60, bs=2 -> lut_qp_o=51, rsp_tc=24.
- Arbitration:
  - After reset, both valid held for 4 edges -> grant order 0,1,0,1.
  - readyN_o never high for both in the same cycle.
- Backpressure and reset:
  - rsp_ready_i=0 for 5 cycles in RESP -> rsp_tc/rsp_id stable, no ready asserted.
  - Assert rst during CALC -> next cycle rsp_valid=0, state IDLE, rr_ptr=0.
- DB_TC_OFFSET_EN:
  - qp_p=qp_q=40, offset=+3, bs=1 -> index 46, tc=11.
  - qp avg 30, offset=-2 -> index 26, tc=1.
  - qp avg 4, offset=-6 -> index 0, tc=0.

Source files
------------

// File: rtl/db_tc_sched.sv
// db_tc_sched: round-robin scheduler sharing one combinational tc LUT between the
// vertical and horizontal deblocking engines. Define DB_TC_OFFSET_EN for slice tc offset.
`ifndef INTER
`define INTER 1'b0
`endif
`ifndef INTRA
`define INTRA 1'b1
`endif

module db_tc_sched #(
    parameter int QP_MAX = 51
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [5:0] req0_qp_p_i,
    input  logic [5:0] req0_qp_q_i,
    input  logic [1:0] req0_bs_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [5:0] req1_qp_p_i,
    input  logic [5:0] req1_qp_q_i,
    input  logic [1:0] req1_bs_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_id_o,
    output logic [4:0] rsp_tc_o,
    output logic [5:0] lut_qp_o,
    output logic       lut_type_o,
    input  logic [4:0] lut_tc_i,
    output logic       busy_o
`ifdef DB_TC_OFFSET_EN
    ,
    input  logic [3:0] tc_offset_div2_i
`endif
);

    localparam logic [5:0] QP_MAX_IDX = 6'(QP_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       rr_ptr_reg, rr_ptr_next;
    logic       id_reg, id_next;
    logic [1:0] bs_reg, bs_next;
    logic [5:0] lut_qp_reg, lut_qp_next;
    logic       lut_type_reg, lut_type_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic       rsp_id_reg, rsp_id_next;
    logic [4:0] rsp_tc_reg, rsp_tc_next;

    logic [1:0] req_valid;
    logic [5:0] req_qp_p [2];
    logic [5:0] req_qp_q [2];
    logic [1:0] req_bs   [2];
    logic [5:0] req_idx  [2];
    logic [1:0] req_bs_eff [2];
    logic [1:0] gnt;
    logic       gnt_id;

    assign req_valid   = {req1_valid_i, req0_valid_i};
    assign req_qp_p[0] = req0_qp_p_i;
    assign req_qp_p[1] = req1_qp_p_i;
    assign req_qp_q[0] = req0_qp_q_i;
    assign req_qp_q[1] = req1_qp_q_i;
    assign req_bs[0]   = req0_bs_i;
    assign req_bs[1]   = req1_bs_i;

    // Each requester gets its own index path so the grant mux sits after the clip.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [6:0] qp_sum;
        logic [6:0] qp_avg;

        assign qp_sum = {1'b0, req_qp_p[gi]} + {1'b0, req_qp_q[gi]} + 7'd1;
        assign qp_avg = {1'b0, qp_sum[6:1]};

`ifdef DB_TC_OFFSET_EN
        localparam logic signed [7:0] QP_MAX_S = 8'(QP_MAX);
        logic signed [7:0] idx_s;

        assign idx_s = $signed({1'b0, qp_avg})
                     + $signed({{3{tc_offset_div2_i[3]}}, tc_offset_div2_i, 1'b0});
        assign req_idx[gi] = idx_s[7]          ? 6'd0 :
                             (idx_s > QP_MAX_S) ? QP_MAX_IDX : idx_s[5:0];
`else
        assign req_idx[gi] = (qp_avg > {1'b0, QP_MAX_IDX}) ? QP_MAX_IDX : qp_avg[5:0];
`endif

        // bs 3 is not a legal strength; fold it onto the strongest filter.
        assign req_bs_eff[gi] = (req_bs[gi] == 2'd3) ? 2'd2 : req_bs[gi];
    end

    assign gnt[0] = (state_reg == IDLE) && req_valid[0] && (!req_valid[1] || !rr_ptr_reg);
    assign gnt[1] = (state_reg == IDLE) && req_valid[1] && (!req_valid[0] ||  rr_ptr_reg);
    assign gnt_id = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        id_next        = id_reg;
        bs_next        = bs_reg;
        lut_qp_next    = lut_qp_reg;
        lut_type_next  = lut_type_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_tc_next    = rsp_tc_reg;
        case (state_reg)
            IDLE: begin
                if (gnt != 2'b00) begin
                    id_next       = gnt_id;
                    bs_next       = req_bs_eff[gnt_id];
                    lut_qp_next   = req_idx[gnt_id];
                    lut_type_next = (req_bs_eff[gnt_id] == 2'd2) ? `INTRA : `INTER;
                    state_next    = CALC;
                end
            end
            CALC: begin
                rsp_tc_next    = (bs_reg == 2'd0) ? 5'd0 : lut_tc_i;
                rsp_id_next    = id_reg;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    rr_ptr_next    = ~rsp_id_reg;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= 1'b0;
            id_reg        <= 1'b0;
            bs_reg        <= 2'd0;
            lut_qp_reg    <= 6'd0;
            lut_type_reg  <= `INTER;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_tc_reg    <= 5'd0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            id_reg        <= id_next;
            bs_reg        <= bs_next;
            lut_qp_reg    <= lut_qp_next;
            lut_type_reg  <= lut_type_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_tc_reg    <= rsp_tc_next;
        end
    end

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];
    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_id_o     = rsp_id_reg;
    assign rsp_tc_o     = rsp_tc_reg;
    assign lut_qp_o     = lut_qp_reg;
    assign lut_type_o   = lut_type_reg;
    assign busy_o       = (state_reg != IDLE);

endmodule
